// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped, write-back, write-allocate cache controller.
// Tag, valid and dirty state live here. The line data lives in an external array.
// The array has a combinational read port and a synchronous write port.
// Misses evict dirty victims to next-level memory and refill over valid/ready.
// Optional feature macro: CACHE_CTRL_STATS_EN enables the hit/miss counters.
// The package INDEX_W must match the module INDEX_W parameter.
//
// Handshake rules:
// - cpu_req is accepted on a clock edge where cpu_req_valid && cpu_req_ready.
// - cpu_rsp_valid is a one-cycle pulse with no back-pressure.
// - mem_req transfers on a clock edge where mem_req_valid && mem_req_ready.
// - Once mem_req_valid is raised, it and its payload stay stable until mem_req_ready.
// - mem_rsp_valid is a one-cycle pulse that arrives only for read requests.

package cache;
   localparam int INDEX_W = 10;
   localparam int DATA_W  = 32;

   typedef logic [DATA_W-1:0] cache_data_t;

   typedef struct packed {
      logic [INDEX_W-1:0] index;
      logic               we;
   } cache_req_t;
endpackage

module cache_ctrl_dm #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_req_valid,
   output logic                cpu_req_ready,
   input  logic                cpu_req_we,
   input  logic [ADDR_W-1:0]   cpu_req_addr,
   input  cache::cache_data_t  cpu_req_wdata,
   output logic                cpu_rsp_valid,
   output cache::cache_data_t  cpu_rsp_rdata,
   output cache::cache_req_t   data_req,
   output cache::cache_data_t  data_write,
   input  cache::cache_data_t  data_read,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_we,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output cache::cache_data_t  mem_req_wdata,
   input  logic                mem_rsp_valid,
   input  cache::cache_data_t  mem_rsp_rdata,
   output logic [31:0]         stat_hits,
   output logic [31:0]         stat_misses
);

   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 2 ** INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      REFILL,
      WAIT_FILL
   } state_t;

   state_t             state, state_next;
   logic               lat_we;
   logic [ADDR_W-1:0]  lat_addr;
   cache::cache_data_t lat_wdata;

   logic [TAG_W-1:0]   tag_mem [LINES];
   logic [LINES-1:0]   valid_bits;
   logic [LINES-1:0]   dirty_bits;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   lat_tag;
   logic               hit;
   logic               fill_done;
   logic               write_hit;

   assign idx       = lat_addr[INDEX_W-1:0];
   assign lat_tag   = lat_addr[ADDR_W-1:INDEX_W];
   assign hit       = valid_bits[idx] && (tag_mem[idx] == lat_tag);
   assign fill_done = (state == WAIT_FILL) && mem_rsp_valid;
   assign write_hit = (state == COMPARE) && hit && lat_we;

   assign cpu_req_ready = (state == IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Latch the request on acceptance; it stays put until the next IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (cpu_req_valid && cpu_req_ready) begin
         lat_we    <= cpu_req_we;
         lat_addr  <= cpu_req_addr;
         lat_wdata <= cpu_req_wdata;
      end
   end

   // Valid/dirty bits: a fill validates the line; a write hit dirties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else if (fill_done) begin
         valid_bits[idx] <= 1'b1;
         dirty_bits[idx] <= lat_we;
      end else if (write_hit) begin
         dirty_bits[idx] <= 1'b1;
      end
   end

   // Tags are meaningless while the valid bit is clear, so they have no reset.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_mem[idx] <= lat_tag;
      end
   end

   // Next state and all combinational outputs.
   always_comb begin
      state_next     = state;
      cpu_rsp_valid  = 1'b0;
      cpu_rsp_rdata  = data_read;
      data_req.index = idx;
      data_req.we    = 1'b0;
      data_write     = lat_wdata;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
      mem_req_addr   = lat_addr;
      mem_req_wdata  = data_read;
      case (state)
         IDLE: begin
            if (cpu_req_valid) state_next = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               cpu_rsp_valid = 1'b1;
               data_req.we   = lat_we;
               state_next    = IDLE;
            end else if (valid_bits[idx] && dirty_bits[idx]) begin
               state_next = WRITEBACK;
            end else begin
               state_next = REFILL;
            end
         end
         WRITEBACK: begin
            // The victim data comes straight from the array.
            // The array is not written in this state, so the payload holds.
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {tag_mem[idx], idx};
            if (mem_req_ready) state_next = REFILL;
         end
         REFILL: begin
            mem_req_valid = 1'b1;
            mem_req_wdata = '0;
            if (mem_req_ready) state_next = WAIT_FILL;
         end
         WAIT_FILL: begin
            if (mem_rsp_valid) begin
               data_req.we   = 1'b1;
               data_write    = lat_we ? lat_wdata : mem_rsp_rdata;
               cpu_rsp_valid = 1'b1;
               cpu_rsp_rdata = mem_rsp_rdata;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef CACHE_CTRL_STATS_EN
   logic [31:0] hits_q, misses_q;

   // Count each lookup once, in the cycle its tag compare resolves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (state == COMPARE) begin
         if (hit) hits_q   <= hits_q + 32'd1;
         else     misses_q <= misses_q + 32'd1;
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif

endmodule
